// File: rtl/morse_quiz_core.sv
// morse_quiz_core: Morse-code quiz engine.
// Picks a pseudo-random letter from an A..Z pattern ROM, plays it on led_out
// at a programmable unit rate, then accepts guesses and reports a sticky
// win or lose.
// Build option: define MORSE_QUIZ_RETRY_EN for multiple tries with automatic
// replay on a miss and an active replay input. Without it, one guess decides
// the round and replay is ignored.
module morse_quiz_core #(
  parameter int PAT_W       = 16,
  parameter int LETTER_BITS = 5,
  parameter int NUM_LETTERS = 26,
  parameter int TICK_DIV    = 25000000,
  parameter int MAX_TRIES   = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   tick_en,
  input  logic                   guess_valid,
  input  logic [LETTER_BITS-1:0] guess,
  input  logic                   replay,
  output logic                   led_out,
  output logic                   busy,
  output logic                   win,
  output logic                   lose,
  output logic [3:0]             tries_left,
  output logic [LETTER_BITS-1:0] letter
);

`ifdef MORSE_QUIZ_RETRY_EN
  localparam bit         RETRY_EN  = 1'b1;
  localparam logic [3:0] EFF_TRIES = 4'(MAX_TRIES);
`else
  localparam bit         RETRY_EN  = 1'b0;
  localparam logic [3:0] EFF_TRIES = 4'd1;
`endif

  localparam int                  PRESC_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_RELOAD = PRESC_W'(TICK_DIV - 1);
  localparam logic [15:0]         LFSR_SEED    = 16'hACE1;

  // Reject parameter sets the ROM, letter index or tries counter cannot hold.
  if ((PAT_W < 13) || (LETTER_BITS < 1) || (LETTER_BITS > 16) ||
      (NUM_LETTERS < 1) || (NUM_LETTERS > 26) ||
      (NUM_LETTERS > (1 << LETTER_BITS)) || (TICK_DIV < 1) ||
      (MAX_TRIES < 1) || (MAX_TRIES > 15)) begin : g_bad_params
    $error("morse_quiz_core: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    GUESS,
    WIN,
    LOSE
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [15:0]          lfsr_q;
  logic [PAT_W-1:0]     sreg_q;
  logic [PRESC_W-1:0]   presc_q;
  logic [LETTER_BITS-1:0] letter_q;
  logic [3:0]           tries_q;

  logic                 tick;
  logic                 last_bit;
  logic                 hit;
  logic                 miss;
  logic                 replay_req;
  logic [3:0]           tries_after_miss;

  // Fibonacci LFSR for x^16+x^14+x^13+x^11+1, shifting right.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // Guesses remaining never wrap below zero.
  function automatic logic [3:0] sat_dec(input logic [3:0] t);
    return (t == 4'd0) ? 4'd0 : t - 4'd1;
  endfunction

  // Morse patterns, LSB first: dot = 1, dash = 111, gap = 0.
  function automatic logic [PAT_W-1:0] rom_pattern(input logic [LETTER_BITS-1:0] idx);
    logic [12:0] p;
    p = 13'h0;
    case (int'(idx))
      0:  p = 13'h001D; // A .-
      1:  p = 13'h0157; // B -...
      2:  p = 13'h05D7; // C -.-.
      3:  p = 13'h0057; // D -..
      4:  p = 13'h0001; // E .
      5:  p = 13'h0175; // F ..-.
      6:  p = 13'h0177; // G --.
      7:  p = 13'h0055; // H ....
      8:  p = 13'h0005; // I ..
      9:  p = 13'h1DDD; // J .---
      10: p = 13'h01D7; // K -.-
      11: p = 13'h015D; // L .-..
      12: p = 13'h0077; // M --
      13: p = 13'h0017; // N -.
      14: p = 13'h0777; // O ---
      15: p = 13'h05DD; // P .--.
      16: p = 13'h1D77; // Q --.-
      17: p = 13'h005D; // R .-.
      18: p = 13'h0015; // S ...
      19: p = 13'h0007; // T -
      20: p = 13'h0075; // U ..-
      21: p = 13'h01D5; // V ...-
      22: p = 13'h01DD; // W .--
      23: p = 13'h0757; // X -..-
      24: p = 13'h1DD7; // Y -.--
      25: p = 13'h0577; // Z --..
      default: p = 13'h0;
    endcase
    return PAT_W'(p);
  endfunction

  assign tick             = (state_q == PLAY) && tick_en && (presc_q == '0);
  assign last_bit         = (sreg_q[PAT_W-1:1] == '0);
  assign hit              = guess_valid && (guess == letter_q) && (int'(guess) < NUM_LETTERS);
  assign miss             = guess_valid && !hit;
  assign replay_req       = RETRY_EN && replay;
  assign tries_after_miss = sat_dec(tries_q);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start overrides everything and always restarts in LOAD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = IDLE;
      LOAD:  state_d = PLAY;
      PLAY: begin
        if (tick && last_bit) begin
          state_d = GUESS;
        end
      end
      GUESS: begin
        if (hit) begin
          state_d = WIN;
        end else if (miss) begin
          state_d = (!RETRY_EN || (tries_after_miss == 4'd0)) ? LOSE : LOAD;
        end else if (replay_req) begin
          state_d = LOAD;
        end
      end
      WIN:     state_d = WIN;
      LOSE:    state_d = LOSE;
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = LOAD;
    end
  end

  // Free-running LFSR; its value at start time picks the letter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  // Round bookkeeping: latched letter and guesses remaining.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      letter_q <= '0;
      tries_q  <= 4'd0;
    end else if (start) begin
      letter_q <= LETTER_BITS'(lfsr_q % 16'(NUM_LETTERS));
      tries_q  <= EFF_TRIES;
    end else if ((state_q == GUESS) && miss) begin
      tries_q  <= tries_after_miss;
    end
  end

  // Playback shift register and unit prescaler; both freeze while tick_en is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg_q  <= '0;
      presc_q <= '0;
    end else if (state_q == LOAD) begin
      sreg_q  <= rom_pattern(letter_q);
      presc_q <= PRESC_RELOAD;
    end else if ((state_q == PLAY) && tick_en) begin
      if (presc_q == '0) begin
        presc_q <= PRESC_RELOAD;
        if (!last_bit) begin
          sreg_q <= sreg_q >> 1;
        end
      end else begin
        presc_q <= presc_q - PRESC_W'(1);
      end
    end
  end

  assign led_out    = (state_q == PLAY) && sreg_q[0];
  assign busy       = (state_q == LOAD) || (state_q == PLAY);
  assign win        = (state_q == WIN);
  assign lose       = (state_q == LOSE);
  assign tries_left = tries_q;
  assign letter     = letter_q;

endmodule

// File: tb/tb_morse_quiz_core.sv
// Testbench for morse_quiz_core: table of letters played and guessed, then
// hand-written sequences for freeze, replay/retry, abort and async reset.
module tb_morse_quiz_core;

  localparam int TD = 4;
`ifdef MORSE_QUIZ_RETRY_EN
  localparam logic [3:0] EFF = 4'd3;
`else
  localparam logic [3:0] EFF = 4'd1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       tick_en;
  logic       guess_valid;
  logic [4:0] guess;
  logic       replay;
  logic       led_out;
  logic       busy;
  logic       win;
  logic       lose;
  logic [3:0] tries_left;
  logic [4:0] letter;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  morse_quiz_core #(
    .PAT_W(16), .LETTER_BITS(5), .NUM_LETTERS(26), .TICK_DIV(TD), .MAX_TRIES(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .tick_en(tick_en),
    .guess_valid(guess_valid), .guess(guess), .replay(replay),
    .led_out(led_out), .busy(busy), .win(win), .lose(lose),
    .tries_left(tries_left), .letter(letter)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // Reference LFSR, stepping on the same edges as the design.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse start on the cycle the LFSR selects the wanted letter; returns in LOAD.
  task automatic start_letter(input int target);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(negedge clk);
      if (int'(m_lfsr % 16'd26) == target) found = 1'b1;
    end
    chk("start_wait", found, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called in LOAD; samples the whole playback and ends in GUESS.
  task automatic play_check(input string name, input logic [15:0] pat, input int nbits);
    logic [63:0] act;
    logic [63:0] exp;
    int bc;
    act = '0;
    exp = '0;
    bc  = int'(busy);
    chk({name, "_load_led"}, led_out, 0);
    for (int c = 0; c < nbits * TD; c++) begin
      @(negedge clk);
      act[c] = led_out;
      exp[c] = pat[c / TD];
      bc += int'(busy);
    end
    @(negedge clk);
    chk({name, "_wave"}, act, exp);
    chk({name, "_busy_cycles"}, bc, nbits * TD + 1);
    chk({name, "_in_guess"}, {busy, led_out}, 0);
  endtask

  task automatic do_guess(input logic [4:0] g, input logic rp);
    guess       = g;
    guess_valid = 1'b1;
    replay      = rp;
    @(negedge clk);
    guess_valid = 1'b0;
    replay      = 1'b0;
  endtask

  typedef struct {
    int          target;
    logic [15:0] pat;
    int          nbits;
    logic [4:0]  g;
    logic        with_replay;
    logic        exp_win;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        t;
    logic [63:0] act;
    logic [63:0] exp;
    logic [15:0] s;

    tbl[0] = '{0,  16'h001D, 5,  5'd0,  1'b0, 1'b1}; // A, correct
    tbl[1] = '{4,  16'h0001, 1,  5'd4,  1'b1, 1'b1}; // E, correct guess beats replay
    tbl[2] = '{9,  16'h1DDD, 13, 5'd8,  1'b0, 1'b0}; // J, wrong
    tbl[3] = '{19, 16'h0007, 3,  5'd19, 1'b0, 1'b1}; // T, correct
    tbl[4] = '{16, 16'h1D77, 13, 5'd31, 1'b0, 1'b0}; // Q, out-of-range guess
    tbl[5] = '{24, 16'h1DD7, 13, 5'd24, 1'b0, 1'b1}; // Y, correct
    tbl[6] = '{2,  16'h05D7, 11, 5'd2,  1'b0, 1'b1}; // C, correct
    tbl[7] = '{10, 16'h01D7, 9,  5'd11, 1'b0, 1'b0}; // K, wrong

    reset = 1'b1; start = 1'b0; tick_en = 1'b1;
    guess_valid = 1'b0; guess = 5'd0; replay = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {led_out, busy, win, lose, tries_left, letter}, 0);
    reset = 1'b0;

    // Table: play each letter, then one guess.
    for (int i = 0; i < 8; i++) begin
      t = tbl[i];
      start_letter(t.target);
      chk($sformatf("v%0d_letter", i), letter, t.target);
      chk($sformatf("v%0d_cleared", i), {win, lose, tries_left}, {2'b00, EFF});
      play_check($sformatf("v%0d", i), t.pat, t.nbits);
      do_guess(t.g, t.with_replay);
      if (t.exp_win) begin
        chk($sformatf("v%0d_win", i), {win, lose, tries_left}, {2'b10, EFF});
      end else begin
`ifdef MORSE_QUIZ_RETRY_EN
        chk($sformatf("v%0d_miss", i), {win, lose, busy, tries_left}, {3'b001, EFF - 4'd1});
`else
        chk($sformatf("v%0d_lose", i), {win, lose, tries_left}, {2'b01, 4'd0});
`endif
      end
    end

    // Freeze tick_en for 10 cycles inside the first unit of A.
    start_letter(0);
    act = '0;
    exp = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      act[c] = led_out;
      exp[c] = (c < 14) || (c >= 18);
      if (c == 1)  tick_en = 1'b0;
      if (c == 11) tick_en = 1'b1;
    end
    @(negedge clk);
    chk("freeze_wave", act, exp);
    chk("freeze_guess", {busy, led_out}, 0);

`ifdef MORSE_QUIZ_RETRY_EN
    // Replay costs nothing; three misses then count down to lose.
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    chk("replay_load", {busy, tries_left}, {1'b1, 4'd3});
    play_check("replay", 16'h001D, 5);
    do_guess(5'd1, 1'b0);
    chk("miss1", {lose, busy, tries_left}, {2'b01, 4'd2});
    play_check("miss1_replay", 16'h001D, 5);
    do_guess(5'd2, 1'b0);
    chk("miss2", {lose, busy, tries_left}, {2'b01, 4'd1});
    play_check("miss2_replay", 16'h001D, 5);
    do_guess(5'd3, 1'b0);
    chk("miss3", {win, lose, busy, tries_left}, {3'b010, 4'd0});
`else
    // Replay is ignored; a single miss loses.
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    chk("replay_ignored", {busy, win, lose, tries_left}, {3'b000, 4'd1});
    @(negedge clk);
    chk("replay_still_guess", {busy, led_out}, 0);
    do_guess(5'd3, 1'b0);
    chk("single_miss", {win, lose, tries_left}, {2'b01, 4'd0});
`endif
    do_guess(5'd0, 1'b0);
    chk("lose_sticky", {win, lose}, 2'b01);

    // Start mid-PLAY aborts the current letter.
    start_letter(9);
    repeat (6) @(negedge clk);
    start_letter(0);
    chk("abort_load", {busy, led_out, letter}, {2'b10, 5'd0});
    play_check("abort_A", 16'h001D, 5);

    // Asynchronous reset between edges during PLAY.
    start_letter(0);
    repeat (2) @(negedge clk);
    chk("pre_reset_led", {busy, led_out}, 2'b11);
    #2 reset = 1'b1;
    #1;
    chk("async_reset", {led_out, busy, win, lose, tries_left, letter}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (7) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = 16'hACE1;
    for (int k = 0; k < 7; k++) s = lfsr_step(s);
    chk("reseed_letter", letter, s % 16'd26);
    chk("reseed_busy", {busy, tries_left}, {1'b1, EFF});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
